interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 The block SHALL have port `clock`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port `enable`, input, 1 bit: the PC updates at the end of this cycle.
REQ-004 The block SHALL have port `irqRequest`, input, 3 bits: interrupt request lines; bit 2 is highest priority.
REQ-005 The block SHALL have port `globalEnable`, input, 1 bit: when 0, no new interrupt entry.
REQ-006 The block SHALL have port `eret`, input, 1 bit: an interrupt-return instruction is executing.
REQ-007 The block SHALL have port `returnPc`, input, 32 bits: the PC value saved on interrupt entry.
REQ-008 The block SHALL have port `interrupted`, output, 1 bit: an interrupt entry pulse to the PC.
REQ-009 The block SHALL have port `interruptReturned`, output, 1 bit: an interrupt return pulse to the PC.
REQ-010 The block SHALL have port `interrupt`, output, 3 bits: one-hot source being entered, else 3'b000.
REQ-011 The block SHALL have port `epc`, output, 32 bits: the top of the EPC stack.
REQ-012 The block SHALL have port `pending`, output, 3 bits: latched, not-yet-entered requests.
REQ-013 The block SHALL have port `inService`, output, 3 bits: sources currently being serviced.
REQ-014 The block SHALL have port `depth`, output, 2 bits: nesting depth, 0 to 3.
REQ-015 The block SHALL have port `spuriousEret`, output, 1 bit: sticky flag for an eret taken at depth 0.
REQ-016 The block SHALL have port `interruptCount`, output, 32 bits: total interrupt entries.

Function
REQ-017 The block SHALL register `irqRequest` as `prevIrq` each cycle; a rising edge (`irqRequest[i] & ~prevIrq[i]`) SHALL set `pending[i]`.
REQ-018 The block SHALL clear `pending[i]` on the edge ending an ENTER for source i; a simultaneous new edge on the same bit SHALL win and leave it set.
REQ-019 The FSM SHALL have exactly the states IDLE, ENTER and RETURN; all outputs SHALL be registered.
REQ-020 In IDLE, when `eret`=1, `enable`=1 and `depth`>0, the next state SHALL be RETURN.
REQ-021 In IDLE, when `eret`=1, `enable`=1 and `depth`=0, the block SHALL set `spuriousEret` and stay in IDLE.
REQ-022 In IDLE, with no eret action, `globalEnable`=1 and `enable`=1, the highest pending bit i that is strictly above the highest `inService` bit SHALL be taken: next state ENTER, `interrupt` = one-hot(i).
REQ-023 When eret and an eligible interrupt coincide, eret SHALL win; the interrupt stays pending.
REQ-024 In ENTER, `interrupted`=1 and `interrupt` SHALL hold its value until a cycle with `enable`=1.
REQ-025 On that enabled edge, the block SHALL push `returnPc` onto the 3-entry EPC stack, set `inService[i]`, clear `pending[i]`, increment `depth` and `interruptCount`, and go to IDLE.
REQ-026 In RETURN, `interruptReturned`=1 and `epc` = stack top, held until a cycle with `enable`=1.
REQ-027 On that enabled edge, the block SHALL pop the stack, clear the highest set `inService` bit, decrement `depth`, and go to IDLE.
REQ-028 The stack SHALL never overflow: strict-priority preemption bounds `depth` at 3.
REQ-029 `epc` SHALL read 0 when `depth`=0.
REQ-030 `interruptCount` SHALL wrap modulo 2^32.
REQ-031 Decision latency SHALL be 1 cycle: eligibility in cycle N gives the pulse in N+1, consumed by the PC at the end of N+1 when enabled.
REQ-032 Requests arriving while in ENTER or RETURN SHALL latch into `pending` and be evaluated only in IDLE.

Reset
REQ-033 On `reset`=1 at a clock edge, the state SHALL become IDLE, even mid-ENTER or mid-RETURN.
REQ-034 On that edge, all outputs, `prevIrq`, and all stack entries SHALL become 0.
REQ-035 A request line held high across reset release SHALL register as an edge on the first cycle after reset.

Verification
REQ-036 Scenario 1: irqRequest=3'b001, globalEnable=1, enable=1, returnPc=0x40 -> the next cycle shows interrupted=1 and interrupt=3'b001; after that edge depth=1, epc=0x40, inService=3'b001, and interruptCount=1.
REQ-037 Scenario 2: in service of 3'b001, raise bit 2 with returnPc=0x10 -> preemption to depth=2, epc=0x10; raising bit 0 again only sets pending[0].
REQ-038 Scenario 3: at depth 2, eret=1 -> interruptReturned=1 with epc=0x10; after that edge depth=1, epc=0x40, inService=3'b001.
REQ-039 Scenario 4: eret and a bit-2 edge in the same cycle -> RETURN first, then ENTER for bit 2 two cycles later.
REQ-040 Scenario 5: in ENTER, hold enable=0 for 3 cycles -> interrupted stays 1 and no push occurs until enable=1.
REQ-041 Scenario 6: eret at depth 0 -> spuriousEret=1 and no pulse; a reset mid-RETURN at depth 2 -> all outputs read 0.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// Signal bundle between the PC/pipeline and the interrupt controller.
interface interrupt_controller_if;
  logic        enable;
  logic [2:0]  irqRequest;
  logic        globalEnable;
  logic        eret;
  logic [31:0] returnPc;
  logic        interrupted;
  logic        interruptReturned;
  logic [2:0]  interrupt;
  logic [31:0] epc;
  logic [2:0]  pending;
  logic [2:0]  inService;
  logic [1:0]  depth;
  logic        spuriousEret;
  logic [31:0] interruptCount;

  modport slave (
    input  enable, irqRequest, globalEnable, eret, returnPc,
    output interrupted, interruptReturned, interrupt, epc, pending,
           inService, depth, spuriousEret, interruptCount
  );

  modport master (
    output enable, irqRequest, globalEnable, eret, returnPc,
    input  interrupted, interruptReturned, interrupt, epc, pending,
           inService, depth, spuriousEret, interruptCount
  );
endinterface

// File: rtl/interrupt_controller.sv
// 3-source nested interrupt controller with a 3-deep EPC stack; 1-cycle decision latency,
// entry/return pulses hold until the PC consumes them with enable=1; all outputs registered.
module interrupt_controller (
  input logic                   clock,
  input logic                   reset,
  interrupt_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ENTER, RETURN} state_t;

  state_t      state, stateNext;
  logic [2:0]  prevIrq;
  logic [31:0] stack [3];
  logic [31:0] stackNext [3];

  logic [2:0]  rise, pendEff, reqOneHot;
  logic [1:0]  svcLevel, reqLevel;
  logic        eligible;

  logic        interruptedNext, interruptReturnedNext, spuriousNext;
  logic [2:0]  interruptNext, pendingNext, inServiceNext;
  logic [31:0] epcNext, countNext;
  logic [1:0]  depthNext;

  function automatic logic [1:0] level(input logic [2:0] v);
    if (v[2])      return 2'd3;
    else if (v[1]) return 2'd2;
    else if (v[0]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [2:0] msbOneHot(input logic [2:0] v);
    if (v[2])      return 3'b100;
    else if (v[1]) return 3'b010;
    else if (v[0]) return 3'b001;
    else           return 3'b000;
  endfunction

  always_comb begin
    rise      = bus.irqRequest & ~prevIrq;
    pendEff   = bus.pending | rise;
    svcLevel  = level(bus.inService);
    reqLevel  = level(pendEff);
    reqOneHot = msbOneHot(pendEff);
    // Strict priority: only a source above everything in service may preempt.
    eligible  = reqLevel > svcLevel;
  end

  always_comb begin
    stateNext     = state;
    pendingNext   = pendEff;
    inServiceNext = bus.inService;
    depthNext     = bus.depth;
    spuriousNext  = bus.spuriousEret;
    countNext     = bus.interruptCount;
    interruptNext = bus.interrupt;
    for (int k = 0; k < 3; k++) stackNext[k] = stack[k];

    case (state)
      IDLE: begin
        interruptNext = 3'b000;
        if (bus.eret && bus.enable) begin
          if (bus.depth != 2'd0) stateNext = RETURN;
          else                   spuriousNext = 1'b1;
        end else if (bus.globalEnable && bus.enable && eligible) begin
          stateNext     = ENTER;
          interruptNext = reqOneHot;
        end
      end
      ENTER: begin
        if (bus.enable) begin
          for (int k = 0; k < 3; k++)
            if (bus.depth == 2'(k)) stackNext[k] = bus.returnPc;
          inServiceNext = bus.inService | bus.interrupt;
          // A fresh edge on the entered source re-arms it.
          pendingNext   = (bus.pending & ~bus.interrupt) | rise;
          depthNext     = bus.depth + 2'd1;
          countNext     = bus.interruptCount + 32'd1;
          interruptNext = 3'b000;
          stateNext     = IDLE;
        end
      end
      RETURN: begin
        if (bus.enable) begin
          for (int k = 0; k < 3; k++)
            if (bus.depth == 2'(k + 1)) stackNext[k] = 32'd0;
          inServiceNext = bus.inService & ~msbOneHot(bus.inService);
          depthNext     = bus.depth - 2'd1;
          stateNext     = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    case (depthNext)
      2'd1:    epcNext = stackNext[0];
      2'd2:    epcNext = stackNext[1];
      2'd3:    epcNext = stackNext[2];
      default: epcNext = 32'd0;
    endcase
    interruptedNext       = (stateNext == ENTER);
    interruptReturnedNext = (stateNext == RETURN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= IDLE;
      prevIrq               <= 3'b000;
      for (int k = 0; k < 3; k++) stack[k] <= 32'd0;
      bus.interrupted       <= 1'b0;
      bus.interruptReturned <= 1'b0;
      bus.interrupt         <= 3'b000;
      bus.epc               <= 32'd0;
      bus.pending           <= 3'b000;
      bus.inService         <= 3'b000;
      bus.depth             <= 2'd0;
      bus.spuriousEret      <= 1'b0;
      bus.interruptCount    <= 32'd0;
    end else begin
      state                 <= stateNext;
      prevIrq               <= bus.irqRequest;
      for (int k = 0; k < 3; k++) stack[k] <= stackNext[k];
      bus.interrupted       <= interruptedNext;
      bus.interruptReturned <= interruptReturnedNext;
      bus.interrupt         <= interruptNext;
      bus.epc               <= epcNext;
      bus.pending           <= pendingNext;
      bus.inService         <= inServiceNext;
      bus.depth             <= depthNext;
      bus.spuriousEret      <= spuriousNext;
      bus.interruptCount    <= countNext;
    end
  end
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
module tb_interrupt_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   fails = 0;

  interrupt_controller_if bus();

  interrupt_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.enable       = 1'b0;
    bus.irqRequest   = 3'b000;
    bus.globalEnable = 1'b0;
    bus.eret         = 1'b0;
    bus.returnPc     = 32'h0;

    // Reset state
    step(); step();
    chk("rst_interrupted", 32'(bus.interrupted), 32'd0);
    chk("rst_depth", 32'(bus.depth), 32'd0);
    chk("rst_epc", bus.epc, 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_count", bus.interruptCount, 32'd0);

    // Scenario 1: first entry
    reset = 1'b0;
    bus.irqRequest = 3'b001; bus.globalEnable = 1'b1; bus.enable = 1'b1; bus.returnPc = 32'h40;
    step();
    chk("s1_interrupted", 32'(bus.interrupted), 32'd1);
    chk("s1_interrupt", 32'(bus.interrupt), 32'b001);
    chk("s1_depth_pre", 32'(bus.depth), 32'd0);
    step();
    chk("s1_depth", 32'(bus.depth), 32'd1);
    chk("s1_epc", bus.epc, 32'h40);
    chk("s1_inservice", 32'(bus.inService), 32'b001);
    chk("s1_count", bus.interruptCount, 32'd1);
    chk("s1_pulse_done", 32'(bus.interrupted), 32'd0);
    chk("s1_pending", 32'(bus.pending), 32'd0);

    // Scenario 2: bit 2 preempts, re-raised bit 0 only pends
    bus.irqRequest = 3'b101; bus.returnPc = 32'h10;
    step();
    chk("s2_interrupt", 32'(bus.interrupt), 32'b100);
    step();
    chk("s2_depth", 32'(bus.depth), 32'd2);
    chk("s2_epc", bus.epc, 32'h10);
    chk("s2_inservice", 32'(bus.inService), 32'b101);
    chk("s2_count", bus.interruptCount, 32'd2);
    bus.irqRequest = 3'b100;
    step();
    bus.irqRequest = 3'b101;
    step();
    chk("s2_pending0", 32'(bus.pending), 32'b001);
    chk("s2_no_entry", 32'(bus.interrupted), 32'd0);
    chk("s2_depth_hold", 32'(bus.depth), 32'd2);

    // Scenario 3: return from depth 2
    bus.eret = 1'b1;
    step();
    chk("s3_returned", 32'(bus.interruptReturned), 32'd1);
    chk("s3_epc_top", bus.epc, 32'h10);
    bus.eret = 1'b0;
    step();
    chk("s3_depth", 32'(bus.depth), 32'd1);
    chk("s3_epc", bus.epc, 32'h40);
    chk("s3_inservice", 32'(bus.inService), 32'b001);
    chk("s3_pulse_done", 32'(bus.interruptReturned), 32'd0);

    // Scenario 4: eret and bit-2 edge together -> RETURN then ENTER
    bus.irqRequest = 3'b001;
    step();
    bus.eret = 1'b1; bus.irqRequest = 3'b101;
    step();
    chk("s4_returned", 32'(bus.interruptReturned), 32'd1);
    chk("s4_not_entered", 32'(bus.interrupted), 32'd0);
    chk("s4_pending", 32'(bus.pending), 32'b101);
    bus.eret = 1'b0;
    step();
    chk("s4_depth0", 32'(bus.depth), 32'd0);
    chk("s4_idle_no_pulse", 32'(bus.interrupted), 32'd0);
    step();
    chk("s4_interrupted", 32'(bus.interrupted), 32'd1);
    chk("s4_interrupt", 32'(bus.interrupt), 32'b100);

    // Scenario 5: ENTER stalled by enable=0
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s5_hold_interrupted", 32'(bus.interrupted), 32'd1);
      chk("s5_hold_depth", 32'(bus.depth), 32'd0);
      chk("s5_hold_count", bus.interruptCount, 32'd2);
    end
    bus.enable = 1'b1; bus.returnPc = 32'h80;
    step();
    chk("s5_depth", 32'(bus.depth), 32'd1);
    chk("s5_epc", bus.epc, 32'h80);
    chk("s5_count", bus.interruptCount, 32'd3);
    chk("s5_inservice", 32'(bus.inService), 32'b100);
    chk("s5_pending", 32'(bus.pending), 32'b001);

    // Scenario 6a: spurious eret at depth 0
    bus.globalEnable = 1'b0; bus.eret = 1'b1;
    step();
    bus.eret = 1'b0;
    step();
    chk("s6_depth0", 32'(bus.depth), 32'd0);
    chk("s6_epc0", bus.epc, 32'd0);
    bus.eret = 1'b1;
    step();
    chk("s6_spurious", 32'(bus.spuriousEret), 32'd1);
    chk("s6_no_ret_pulse", 32'(bus.interruptReturned), 32'd0);
    chk("s6_no_int_pulse", 32'(bus.interrupted), 32'd0);
    bus.eret = 1'b0;

    // Scenario 6b: build depth 2 then reset mid-RETURN
    bus.globalEnable = 1'b1;
    step();
    chk("s6_enter0", 32'(bus.interrupt), 32'b001);
    step();
    bus.irqRequest = 3'b011;
    step();
    chk("s6_enter1", 32'(bus.interrupt), 32'b010);
    step();
    chk("s6_depth2", 32'(bus.depth), 32'd2);
    chk("s6_count", bus.interruptCount, 32'd5);
    bus.eret = 1'b1;
    step();
    chk("s6_in_return", 32'(bus.interruptReturned), 32'd1);
    bus.eret = 1'b0; bus.enable = 1'b0; reset = 1'b1;
    step();
    chk("s6_rst_returned", 32'(bus.interruptReturned), 32'd0);
    chk("s6_rst_interrupted", 32'(bus.interrupted), 32'd0);
    chk("s6_rst_interrupt", 32'(bus.interrupt), 32'd0);
    chk("s6_rst_epc", bus.epc, 32'd0);
    chk("s6_rst_pending", 32'(bus.pending), 32'd0);
    chk("s6_rst_inservice", 32'(bus.inService), 32'd0);
    chk("s6_rst_depth", 32'(bus.depth), 32'd0);
    chk("s6_rst_spurious", 32'(bus.spuriousEret), 32'd0);
    chk("s6_rst_count", bus.interruptCount, 32'd0);

    // Line held high across reset release counts as an edge
    reset = 1'b0; bus.enable = 1'b1;
    step();
    chk("rel_interrupted", 32'(bus.interrupted), 32'd1);
    chk("rel_interrupt", 32'(bus.interrupt), 32'b010);
    chk("rel_pending", 32'(bus.pending), 32'b011);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
